// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM access sequencer: state encoding, default
// geometry and the RWS line polarity.
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 4;

    localparam logic RWS_READ  = 1'b0;
    localparam logic RWS_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ram_burst_counter.sv
// Burst address generator: loadable address that wraps at 2^ADDR_W plus a
// beats-remaining down-counter that flags the final beat.
module ram_burst_counter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_beat_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    // Stepping on the final beat is ignored so the address stays on the last word.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = addr_i;
            cnt_d  = len_i;
        end else if (step_i && (cnt_q != '0)) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o      = addr_q;
    assign last_beat_o = (cnt_q == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Host-side sequencer for the 1K x 8 RAM: single/burst read and write over a
// valid/ready request, with a SETUP turnaround cycle before every beat.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_rws,
    output logic              ram_cs,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam int              LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              load, step, last_beat, rd_last;

    logic              req_ready_q, busy_q, wr_ready_q, rd_valid_q, done_q;
    logic              ram_en_q, ram_rws_q, ram_cs_q;
    logic [DATA_W-1:0] rd_data_q;

    ram_burst_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .addr_i      (req_addr),
        .len_i       (req_len),
        .step_i      (step),
        .addr_o      (ram_addr),
        .last_beat_o (last_beat)
    );

    assign rd_last = (state_q == ST_READ) && (lat_q == LAT_LAST);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        lat_d   = lat_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    load    = 1'b1;
                    dir_d   = req_write ? RWS_WRITE : RWS_READ;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                lat_d   = '0;
                state_d = (dir_q == RWS_WRITE) ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                step    = 1'b1;
                state_d = last_beat ? ST_DONE : ST_SETUP;
            end
            ST_READ: begin
                if (rd_last) begin
                    step    = 1'b1;
                    state_d = last_beat ? ST_DONE : ST_SETUP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= RWS_READ;
            lat_q       <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_rws_q   <= RWS_READ;
            ram_cs_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            lat_q       <= lat_d;
            req_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            wr_ready_q  <= (state_d == ST_WRITE);
            rd_valid_q  <= rd_last;
            done_q      <= (state_d == ST_DONE);
            ram_en_q    <= state_d inside {ST_SETUP, ST_WRITE, ST_READ};
            ram_rws_q   <= (state_d == ST_WRITE) ? RWS_WRITE : RWS_READ;
            ram_cs_q    <= state_d inside {ST_WRITE, ST_READ};
            if (rd_last) begin
                rd_data_q <= ram_data;
            end
        end
    end

    // Drive only while in WRITE; reset clears state_q and floats the bus at once.
    assign ram_data = (state_q == ST_WRITE) ? wr_data : {DATA_W{1'bz}};

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign ram_en    = ram_en_q;
    assign ram_rws   = ram_rws_q;
    assign ram_cs    = ram_cs_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl with a behavioural 1K x 8 RAM, a shadow memory
// reference and latency formulas for write and read bursts.
module tb_ram_access_ctrl;

    localparam int         ADDR_W    = 10;
    localparam int         DATA_W    = 8;
    localparam int         LEN_W     = 4;
    localparam int         RD_LAT    = 2;
    localparam int         DEPTH     = 1024;
    localparam logic [7:0] FLOAT_PAT = 8'h3C;
    localparam logic [7:0] IDLE_WR   = 8'hC3;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wr_data;
    logic              req_ready, wr_ready, rd_valid, done, busy;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en, ram_rws, ram_cs;
    wire  [DATA_W-1:0] ram_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bus_viol = 0;
    bit mon_on = 1'b0;

    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] wq[$];
    int         wlog_a[$];
    logic [7:0] wlog_d[$];
    logic [7:0] rlog[$];
    int         rcyc[$];
    int         dlog[$];
    int         cslog[$];

    always #5 clk = ~clk;

    ram_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_rws   (ram_rws),
        .ram_cs    (ram_cs),
        .ram_data  (ram_data)
    );

    // RAM model: combinational read, write on the rising edge.
    wire ram_rd_en = ram_en && ram_cs && !ram_rws;
    assign ram_data = ram_rd_en ? mem[ram_addr] : 8'hzz;
    // While CS is low a known pattern stands in for a floating bus, so any
    // stray controller drive shows up as a corrupted value.
    assign ram_data = !ram_cs ? FLOAT_PAT : 8'hzz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en && ram_cs && ram_rws) begin
            mem[ram_addr] = ram_data;
            wlog_a.push_back(int'(ram_addr));
            wlog_d.push_back(ram_data);
        end
    end

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (rd_valid) begin
                rlog.push_back(rd_data);
                rcyc.push_back(cyc);
            end
            if (done) dlog.push_back(cyc);
            if (ram_cs) cslog.push_back(cyc);
            bus_viol <= bus_viol + int'(!ram_cs && (ram_data !== FLOAT_PAT))
                                 + int'(ram_rd_en && (ram_data !== mem[ram_addr]));
        end
    end

    always @(negedge clk) begin
        if (wr_ready && wq.size() > 0) wr_data = wq.pop_front();
        else if (!wr_ready)            wr_data = IDLE_WR;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        wlog_a.delete(); wlog_d.delete(); rlog.delete();
        rcyc.delete(); dlog.delete(); cslog.delete();
    endtask

    // Presents a request at a negedge; acc is the cycle in which it is accepted.
    task automatic issue(input logic wr, input int a, input int len, output int acc);
        clear_logs();
        acc       = -1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = ADDR_W'(a);
        req_len   = LEN_W'(len);
        for (int k = 0; k < 50; k++) begin
            if (req_ready) begin acc = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int want, input int limit, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk); #1;
            if (dlog.size() >= want) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, busy, wr_ready, rd_valid, done, ram_en, ram_cs, ram_rws} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 10000000",
                     {req_ready, busy, wr_ready, rd_valid, done, ram_en, ram_cs, ram_rws});
        end
        checks++;
        if (ram_addr !== 10'd0 || rd_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: got addr=%0h rd=%0h required 0 0", ram_addr, rd_data);
        end
        checks++;
        if (ram_data !== FLOAT_PAT) begin
            failures++;
            $display("FAIL reset_bus: got %0h required %0h", ram_data, FLOAT_PAT);
        end
        rst    = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        int acc;
        bit seen;
        wq.delete();
        wq.push_back(8'hA5);
        issue(1'b1, 'h005, 0, acc);
        wait_done(1, 50, seen);
        ref_mem[5] = 8'hA5;
        checks++;
        if (!seen || dlog[0] != acc + 3) begin
            failures++;
            $display("FAIL single_wr_done: got seen=%0d cyc=%0d required cyc=%0d", seen, seen ? dlog[0] : -1, acc + 3);
        end
        checks++;
        if (wlog_a.size() != 1 || cslog.size() != 1) begin
            failures++;
            $display("FAIL single_wr_beats: got writes=%0d cs_cycles=%0d required 1 1", wlog_a.size(), cslog.size());
        end else begin
            checks++;
            if (wlog_a[0] != 5 || wlog_d[0] !== 8'hA5) begin
                failures++;
                $display("FAIL single_wr_beat: got addr=%0h data=%0h required 5 a5", wlog_a[0], wlog_d[0]);
            end
        end
        issue(1'b0, 'h005, 0, acc);
        wait_done(1, 50, seen);
        checks++;
        if (rlog.size() != 1 || rlog[0] !== 8'hA5) begin
            failures++;
            $display("FAIL single_rd_data: got n=%0d data=%0h required n=1 data=a5", rlog.size(), rlog.size() > 0 ? rlog[0] : 8'h00);
        end
        checks++;
        if (!seen || dlog[0] != acc + (1 + RD_LAT) + 1) begin
            failures++;
            $display("FAIL single_rd_done: got seen=%0d cyc=%0d required %0d", seen, seen ? dlog[0] : -1, acc + RD_LAT + 2);
        end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] pat [4];
        int acc;
        bit seen;
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            wq.push_back(pat[i]);
            ref_mem[('h3FE + i) % DEPTH] = pat[i];
        end
        issue(1'b1, 'h3FE, 3, acc);
        wait_done(1, 60, seen);
        checks++;
        if (!seen || wlog_a.size() != 4 || dlog[0] != acc + 2 * 4 + 1) begin
            failures++;
            $display("FAIL burst_wr_shape: got seen=%0d writes=%0d required 4 writes done at %0d", seen, wlog_a.size(), acc + 9);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wlog_a[i] != ('h3FE + i) % DEPTH || wlog_d[i] !== pat[i]) begin
                    failures++;
                    $display("FAIL burst_wr_beat%0d: got addr=%0h data=%0h required %0h %0h",
                             i, wlog_a[i], wlog_d[i], ('h3FE + i) % DEPTH, pat[i]);
                end
            end
        end
        issue(1'b0, 'h3FE, 3, acc);
        wait_done(1, 80, seen);
        checks++;
        if (rlog.size() != 4) begin
            failures++;
            $display("FAIL burst_rd_count: got %0d required 4", rlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rlog[i] !== pat[i]) begin
                    failures++;
                    $display("FAIL burst_rd_beat%0d: got %0h required %0h", i, rlog[i], pat[i]);
                end
            end
        end
    endtask

    task automatic test_read_latency();
        int acc;
        bit seen;
        mem['h100]     = 8'h5C;
        ref_mem['h100] = 8'h5C;
        issue(1'b0, 'h100, 0, acc);
        wait_done(1, 50, seen);
        checks++;
        if (cslog.size() != RD_LAT) begin
            failures++;
            $display("FAIL rdlat_cs_cycles: got %0d required %0d", cslog.size(), RD_LAT);
        end
        checks++;
        if (rlog.size() != 1 || rlog[0] !== 8'h5C || rcyc[0] != acc + 1 + RD_LAT + 1) begin
            failures++;
            $display("FAIL rdlat_valid: got n=%0d cyc=%0d required 5c at cyc %0d",
                     rlog.size(), rcyc.size() > 0 ? rcyc[0] : -1, acc + RD_LAT + 2);
        end
        checks++;
        if (!seen || dlog[0] != acc + 1 * (1 + RD_LAT) + 1) begin
            failures++;
            $display("FAIL rdlat_done: got cyc=%0d required %0d", seen ? dlog[0] : -1, acc + RD_LAT + 2);
        end
    endtask

    task automatic test_back_to_back();
        int a, n, acc1, acc2, d1;
        bit seen;
        logic [7:0] d;
        a = $urandom_range(0, DEPTH - 1);
        n = $urandom_range(2, 4);
        wq.delete();
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            wq.push_back(d);
            ref_mem[(a + i) % DEPTH] = d;
        end
        clear_logs();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = ADDR_W'(a);
        req_len   = LEN_W'(n - 1);
        acc1 = -1;
        for (int k = 0; k < 50; k++) begin
            if (req_ready) begin acc1 = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_write = 1'b0;
        d1   = -1;
        acc2 = -1;
        for (int k = 0; k < 100; k++) begin
            if (req_ready) begin acc2 = cyc; break; end
            if (done) d1 = cyc;
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(2, 100, seen);
        checks++;
        if (d1 != acc1 + 2 * n + 1) begin
            failures++;
            $display("FAIL b2b_first_done: got %0d required %0d", d1, acc1 + 2 * n + 1);
        end
        checks++;
        if (acc2 != d1 + 1) begin
            failures++;
            $display("FAIL b2b_second_accept: got %0d required %0d", acc2, d1 + 1);
        end
        checks++;
        if (!seen || dlog[1] != acc2 + n * (1 + RD_LAT) + 1) begin
            failures++;
            $display("FAIL b2b_second_done: got seen=%0d required cyc %0d", seen, acc2 + n * (1 + RD_LAT) + 1);
        end
        checks++;
        if (rlog.size() != n) begin
            failures++;
            $display("FAIL b2b_rd_count: got %0d required %0d", rlog.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rlog[i] !== ref_mem[(a + i) % DEPTH]) begin
                    failures++;
                    $display("FAIL b2b_rd_beat%0d: got %0h required %0h", i, rlog[i], ref_mem[(a + i) % DEPTH]);
                end
            end
        end
    endtask

    task automatic test_random();
        int a, len, n, acc, lim;
        bit seen;
        logic [7:0] d;
        for (int it = 0; it < 8; it++) begin
            if (it % 2 == 0) begin
                a   = $urandom_range(0, DEPTH - 1);
                len = $urandom_range(0, 15);
            end
            n   = len + 1;
            lim = n * (2 + RD_LAT) + 20;
            if (it % 2 == 0) begin
                wq.delete();
                for (int i = 0; i < n; i++) begin
                    d = 8'($urandom);
                    wq.push_back(d);
                    ref_mem[(a + i) % DEPTH] = d;
                end
                issue(1'b1, a, len, acc);
                wait_done(1, lim, seen);
                checks++;
                if (!seen || dlog[0] != acc + 2 * n + 1 || wlog_a.size() != n) begin
                    failures++;
                    $display("FAIL rand_wr%0d_shape: got seen=%0d writes=%0d required %0d writes done at %0d",
                             it, seen, wlog_a.size(), n, acc + 2 * n + 1);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        checks++;
                        if (wlog_a[i] != (a + i) % DEPTH || wlog_d[i] !== ref_mem[(a + i) % DEPTH]) begin
                            failures++;
                            $display("FAIL rand_wr%0d_beat%0d: got %0h/%0h required %0h/%0h", it, i,
                                     wlog_a[i], wlog_d[i], (a + i) % DEPTH, ref_mem[(a + i) % DEPTH]);
                        end
                    end
                end
            end else begin
                issue(1'b0, a, len, acc);
                wait_done(1, lim, seen);
                checks++;
                if (!seen || dlog[0] != acc + n * (1 + RD_LAT) + 1 || rlog.size() != n) begin
                    failures++;
                    $display("FAIL rand_rd%0d_shape: got seen=%0d reads=%0d required %0d reads done at %0d",
                             it, seen, rlog.size(), n, acc + n * (1 + RD_LAT) + 1);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        checks++;
                        if (rlog[i] !== ref_mem[(a + i) % DEPTH]) begin
                            failures++;
                            $display("FAIL rand_rd%0d_beat%0d: got %0h required %0h", it, i, rlog[i], ref_mem[(a + i) % DEPTH]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int a, acc;
        logic [7:0] d0, old1;
        a    = $urandom_range(0, DEPTH - 1);
        d0   = 8'($urandom);
        old1 = ref_mem[(a + 1) % DEPTH];
        wq.delete();
        wq.push_back(d0);
        wq.push_back(~old1);
        wq.push_back(8'($urandom));
        wq.push_back(8'($urandom));
        issue(1'b1, a, 3, acc);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wr_ready !== 1'b1 || cyc != acc + 4) begin
            failures++;
            $display("FAIL rstmid_in_beat2: got wr_ready=%0b cyc=%0d required 1 at %0d", wr_ready, cyc, acc + 4);
        end
        #1;
        rst     = 1'b1;
        wr_data = IDLE_WR;
        #1;
        checks++;
        if (ram_cs !== 1'b0 || req_ready !== 1'b1 || ram_data !== FLOAT_PAT) begin
            failures++;
            $display("FAIL rstmid_abort: got cs=%0b ready=%0b bus=%0h required 0 1 %0h", ram_cs, req_ready, ram_data, FLOAT_PAT);
        end
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        repeat (6) @(negedge clk);
        ref_mem[a] = d0;
        checks++;
        if (dlog.size() != 0 || wlog_a.size() != 1) begin
            failures++;
            $display("FAIL rstmid_no_done: got dones=%0d writes=%0d required 0 1", dlog.size(), wlog_a.size());
        end
        checks++;
        if (mem[a] !== d0 || mem[(a + 1) % DEPTH] !== old1) begin
            failures++;
            $display("FAIL rstmid_ram: got %0h %0h required %0h %0h", mem[a], mem[(a + 1) % DEPTH], d0, old1);
        end
    endtask

    task automatic test_bus_invariant();
        checks++;
        if (bus_viol != 0) begin
            failures++;
            $display("FAIL bus_conflict: got %0d violations required 0", bus_viol);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_data   = IDLE_WR;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_read_latency();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        test_bus_invariant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
